// File: rtl/hdc_pkg.sv
// Shared types and width helpers for the hypervector popcount datapath.
package hdc_pkg;

  // Frame-level control states of the stream accumulator.
  typedef enum logic [1:0] {
    S_ACC   = 2'd0,
    S_DRAIN = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  // Bits needed to hold a count of 0..n ones.
  function automatic int unsigned popcount_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/popcount_tree.sv
// Combinational popcount of a W-bit vector built as a recursive pairwise adder tree.
// W must be a power of two; each level splits the vector in half and adds the halves.
module popcount_tree
  import hdc_pkg::*;
#(
  parameter int unsigned W = 512
) (
  input  logic [W-1:0]               data,
  output logic [popcount_w(W)-1:0]   count
);

  localparam int unsigned OW = popcount_w(W);

  if (W == 1) begin : g_leaf

    // A single bit is its own popcount.
    always_comb count = data;

  end else begin : g_split

    localparam int unsigned H  = W / 2;
    localparam int unsigned HW = popcount_w(H);

    logic [HW-1:0] cnt_lo;
    logic [HW-1:0] cnt_hi;

    popcount_tree #(.W(H)) u_lo (
      .data  (data[H-1:0]),
      .count (cnt_lo)
    );

    popcount_tree #(.W(H)) u_hi (
      .data  (data[W-1:H]),
      .count (cnt_hi)
    );

    // Combine both half counts at one extra bit of width.
    always_comb count = OW'(cnt_lo) + OW'(cnt_hi);

  end

endmodule

// File: rtl/popcount_stream_accum.sv
// Streams one hypervector in as NUM_CHUNKS beats, popcounts each beat through a
// registered adder tree, accumulates the frame total and presents it with a
// threshold-compare flag on a valid/ready output.
module popcount_stream_accum
  import hdc_pkg::*;
#(
  parameter  int unsigned CHUNK_W    = 512,
  parameter  int unsigned NUM_CHUNKS = 16,
  localparam int unsigned SUM_W      = popcount_w(CHUNK_W * NUM_CHUNKS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               abort,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CHUNK_W-1:0] in_data,
  input  logic [SUM_W-1:0]   thresh,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SUM_W-1:0]   out_sum,
  output logic               out_ge
);

  localparam int unsigned      PC_W      = popcount_w(CHUNK_W);
  localparam int unsigned      CNT_W     = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_CHUNKS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] beat_cnt;
  logic             pc_v;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  pc_d;
  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] acc_sum;
  logic             beat_fire;
  logic             last_beat;
  logic             final_add;
  logic             out_fire;

  popcount_tree #(.W(CHUNK_W)) u_tree (
    .data  (in_data),
    .count (pc_d)
  );

  // Input is accepted only while collecting beats.
  always_comb in_ready = (state == S_ACC);

  // Handshake qualifiers; a beat presented alongside abort never counts.
  always_comb begin
    beat_fire = in_valid & in_ready & ~abort;
    last_beat = beat_fire & (beat_cnt == LAST_BEAT);
    final_add = (state == S_DRAIN) & pc_v;
    out_fire  = out_valid & out_ready;
    acc_sum   = acc + SUM_W'(pc_q);
  end

  // Next-state and result-valid decode.
  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    case (state)
      S_ACC: begin
        if (last_beat) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (final_add) state_nxt = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_ACC;
      end
      default: state_nxt = S_ACC;
    endcase
    if (abort) state_nxt = S_ACC;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_ACC;
    else     state <= state_nxt;
  end

  // Accepted-beat counter; wraps to zero on the last beat of a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (abort) begin
      beat_cnt <= '0;
    end else if (beat_fire) begin
      beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
    end
  end

  // Stage 1: register the per-beat popcount.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_v <= 1'b0;
      pc_q <= '0;
    end else begin
      pc_v <= beat_fire;
      if (beat_fire) pc_q <= pc_d;
    end
  end

  // Stage 2: accumulate beat popcounts; cleared by abort or result hand-off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (abort || (state == S_OUT && out_fire)) begin
      acc <= '0;
    end else if (pc_v) begin
      acc <= acc_sum;
    end
  end

  // Capture the frame total and threshold flag on the final accumulate only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sum <= '0;
      out_ge  <= 1'b0;
    end else if (!abort && final_add) begin
      out_sum <= acc_sum;
      out_ge  <= (acc_sum >= thresh);
    end
  end

endmodule

// File: tb/tb_popcount_stream_accum.sv
// Self-checking bench for popcount_stream_accum at default parameters.
module tb_popcount_stream_accum;

  localparam int unsigned CW = 512;
  localparam int unsigned NC = 16;
  localparam int unsigned SW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          abort;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_data;
  logic [SW-1:0] thresh;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_sum;
  logic          out_ge;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    logic [SW-1:0] sum;
    logic          ge;
  } exp_t;

  exp_t sb[$];

  popcount_stream_accum #(.CHUNK_W(CW), .NUM_CHUNKS(NC)) dut (
    .clk       (clk),
    .rst       (rst),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .thresh    (thresh),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ge    (out_ge)
  );

  always #5 clk = ~clk;

  // Beat patterns: 0 all ones, 1 all zeros, 2 one-hot bit k, other alternating 10.
  function automatic logic [CW-1:0] beat_of(input int pat, input int k);
    logic [CW-1:0] b;
    case (pat)
      0:       b = '1;
      1:       b = '0;
      2:       begin b = '0; b[k] = 1'b1; end
      default: b = {(CW/2){2'b10}};
    endcase
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present beats first..first+count-1, retrying until each is accepted.
  task automatic send_beats(input int pat, input int first, input int count,
                            input int gap_pct, output bit ok);
    ok = 1'b1;
    for (int k = first; k < first + count; k++) begin
      bit accepted = 1'b0;
      int tries    = 0;
      while (!accepted) begin
        if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
          in_valid = 1'b0;
        end else begin
          in_valid = 1'b1;
          in_data  = beat_of(pat, k);
          accepted = in_ready;
        end
        tick();
        tries++;
        if (tries > 200) begin
          ok       = 1'b0;
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  // Push the expected result of a whole frame, then drive it.
  task automatic send_frame(input int pat, input int gap_pct, input logic [SW-1:0] th);
    int unsigned s = 0;
    bit ok;
    exp_t e;
    for (int k = 0; k < int'(NC); k++) s += $countones(beat_of(pat, k));
    e.sum = SW'(s);
    e.ge  = (s >= th);
    sb.push_back(e);
    thresh = th;
    send_beats(pat, 0, NC, gap_pct, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_timeout: beat not accepted, in_ready=%0b required 1", in_ready);
    end
  endtask

  // Wait (bounded) for out_valid and sample the result.
  task automatic get_result(output logic [SW-1:0] s, output logic g, output bit ok);
    for (int i = 0; i < 50; i++) begin
      if (out_valid) break;
      tick();
    end
    ok = out_valid;
    s  = out_sum;
    g  = out_ge;
  endtask

  task automatic test_reset();
    rst = 1'b1; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    thresh = '0; out_ready = 1'b0;
    #2;
    n_checks++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_ge !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b sum=%0d ge=%0b required 0/0/0", out_valid, out_sum, out_ge);
    end
    tick(); tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %0b required 1", in_ready);
    end
  endtask

  task automatic test_all_ones();
    logic [SW-1:0] s; logic g; bit ok; exp_t e;
    out_ready = 1'b1;
    send_frame(0, 0, 14'd8192);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ones_lat1: got v=%0b rdy=%0b required v=0 rdy=0", out_valid, in_ready);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ones_lat2: out_valid got %0b required 1", out_valid);
    end
    get_result(s, g, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || s !== e.sum || g !== e.ge) begin
      n_fail++;
      $display("FAIL ones_result: got v=%0b sum=%0d ge=%0b required sum=%0d ge=%0b", ok, s, g, e.sum, e.ge);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ones_handoff: got v=%0b rdy=%0b required v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_zeros_thresh();
    logic [SW-1:0] s; logic g; bit ok; exp_t e;
    out_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      send_frame(1, 0, SW'(t));
      get_result(s, g, ok);
      e = sb.pop_front();
      n_checks++;
      if (!ok || s !== e.sum || g !== e.ge) begin
        n_fail++;
        $display("FAIL zeros_th%0d: got v=%0b sum=%0d ge=%0b required sum=%0d ge=%0b", t, ok, s, g, e.sum, e.ge);
      end
      tick();
    end
  endtask

  task automatic test_onehot_gaps();
    logic [SW-1:0] s; logic g; bit ok; exp_t e;
    out_ready = 1'b1;
    send_frame(2, 40, 14'd16);
    get_result(s, g, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || s !== e.sum || g !== e.ge) begin
      n_fail++;
      $display("FAIL onehot_gaps: got v=%0b sum=%0d ge=%0b required sum=%0d ge=%0b", ok, s, g, e.sum, e.ge);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [SW-1:0] s; logic g; bit ok; exp_t e;
    out_ready = 1'b0;
    send_frame(3, 0, 14'd4096);
    get_result(s, g, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || s !== e.sum || g !== e.ge) begin
      n_fail++;
      $display("FAIL bp_result: got v=%0b sum=%0d ge=%0b required sum=%0d ge=%0b", ok, s, g, e.sum, e.ge);
    end
    // Threshold moves after capture; the held flag must not follow it.
    thresh = 14'd5000;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_sum !== e.sum || out_ge !== e.ge || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%0b sum=%0d ge=%0b rdy=%0b required 1/%0d/%0b/0",
                 i, out_valid, out_sum, out_ge, in_ready, e.sum, e.ge);
      end
    end
    // A beat offered during the handshake cycle must wait one cycle.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = '1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_handoff: got v=%0b rdy=%0b required v=0 rdy=1", out_valid, in_ready);
    end
    send_frame(0, 0, 14'd8192);
    get_result(s, g, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || s !== e.sum || g !== e.ge) begin
      n_fail++;
      $display("FAIL bp_next_frame: got v=%0b sum=%0d ge=%0b required sum=%0d ge=%0b", ok, s, g, e.sum, e.ge);
    end
    tick();
  endtask

  task automatic test_abort();
    logic [SW-1:0] s; logic g; bit ok; exp_t e;
    out_ready = 1'b1;
    thresh    = 14'd8192;
    send_beats(0, 0, 7, 0, ok);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = '1;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_acc_state: got v=%0b rdy=%0b required v=0 rdy=1", out_valid, in_ready);
    end
    send_frame(0, 0, 14'd8192);
    get_result(s, g, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || s !== e.sum || g !== e.ge) begin
      n_fail++;
      $display("FAIL abort_frame: got v=%0b sum=%0d ge=%0b required sum=%0d ge=%0b", ok, s, g, e.sum, e.ge);
    end
    tick();
    // Abort while a result waits in S_OUT discards it.
    out_ready = 1'b0;
    send_frame(2, 0, 14'd16);
    get_result(s, g, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || s !== e.sum) begin
      n_fail++;
      $display("FAIL abort_pre_out: got v=%0b sum=%0d required sum=%0d", ok, s, e.sum);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_out: got v=%0b rdy=%0b required v=0 rdy=1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    send_frame(1, 0, 14'd0);
    get_result(s, g, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || s !== e.sum || g !== e.ge) begin
      n_fail++;
      $display("FAIL abort_after_out: got v=%0b sum=%0d ge=%0b required sum=%0d ge=%0b", ok, s, g, e.sum, e.ge);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0] s; logic g; bit ok; exp_t e;
    out_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      send_frame((f == 0) ? 0 : 2, 0, (f == 0) ? 14'd8192 : 14'd16);
      get_result(s, g, ok);
      e = sb.pop_front();
      n_checks++;
      if (!ok || s !== e.sum || g !== e.ge) begin
        n_fail++;
        $display("FAIL b2b_frame%0d: got v=%0b sum=%0d ge=%0b required sum=%0d ge=%0b", f, ok, s, g, e.sum, e.ge);
      end
    end
    tick();
    // Reset in the middle of a third frame.
    send_beats(0, 0, 5, 0, ok);
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_ge !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_rst_outputs: got v=%0b sum=%0d ge=%0b required 0/0/0", out_valid, out_sum, out_ge);
    end
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_rst_ready: got %0b required 1", in_ready);
    end
    send_frame(2, 0, 14'd16);
    get_result(s, g, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || s !== e.sum || g !== e.ge) begin
      n_fail++;
      $display("FAIL b2b_after_rst: got v=%0b sum=%0d ge=%0b required sum=%0d ge=%0b", ok, s, g, e.sum, e.ge);
    end
    tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d entries required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_zeros_thresh();
    test_onehot_gaps();
    test_backpressure();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
